// File: rtl/bsg_cgol_rule_array_if.sv
// ---------------------------------------------------------------------------
// bsg_cgol_rule_array_if
//
// Purpose:
//   Bundles the host-facing load/run handshake and the board readout of
//   bsg_cgol_rule_array, so the loader, the display side and the board
//   itself share one set of wires.
//
// Parameters (must match the bsg_cgol_rule_array instance it connects to):
//   board_width_p   columns W
//   board_height_p  rows H
//   gen_width_p     width of generation request and counter
//
// Signals (named from the board's point of view):
//   load_v_i        write data_i into the board (taken only when ready_o)
//   data_i          board image, cell (r,c) at bit H*W-1-r*W-c
//   start_v_i       start a run (taken only when ready_o)
//   num_gens_i      generations to run, sampled on start
//   birth_mask_i    bit n: dead cell with n live neighbours is born
//   survive_mask_i  bit n: live cell with n live neighbours survives
//   ready_o         board is idle and accepts load/start
//   done_o          one-cycle pulse when a run finishes
//   data_o          current board, same bit mapping as data_i
//   gen_cnt_o       generations applied since the last load
//   stable_o        last run stopped because the board stopped changing
//   extinct_o       board is all dead
//
// Modports:
//   master  host/loader side, drives the requests and observes the results
//   slave   the board itself
// ---------------------------------------------------------------------------
interface bsg_cgol_rule_array_if #(
    parameter int board_width_p  = 8,
    parameter int board_height_p = 8,
    parameter int gen_width_p    = 16
);

    localparam int cells_lp = board_width_p * board_height_p;

    logic                   load_v_i;
    logic [cells_lp-1:0]    data_i;
    logic                   start_v_i;
    logic [gen_width_p-1:0] num_gens_i;
    logic [8:0]             birth_mask_i;
    logic [8:0]             survive_mask_i;

    logic                   ready_o;
    logic                   done_o;
    logic [cells_lp-1:0]    data_o;
    logic [gen_width_p-1:0] gen_cnt_o;
    logic                   stable_o;
    logic                   extinct_o;

    modport master (
        output load_v_i,
        output data_i,
        output start_v_i,
        output num_gens_i,
        output birth_mask_i,
        output survive_mask_i,
        input  ready_o,
        input  done_o,
        input  data_o,
        input  gen_cnt_o,
        input  stable_o,
        input  extinct_o
    );

    modport slave (
        input  load_v_i,
        input  data_i,
        input  start_v_i,
        input  num_gens_i,
        input  birth_mask_i,
        input  survive_mask_i,
        output ready_o,
        output done_o,
        output data_o,
        output gen_cnt_o,
        output stable_o,
        output extinct_o
    );

endinterface

// File: rtl/bsg_cgol_rule_array.sv
// ---------------------------------------------------------------------------
// bsg_cgol_rule_array
//
// Purpose:
//   H x W cellular-automaton board with a run-time life-like rule
//   (birth/survive masks indexed by live-neighbour count). A host loads an
//   image, then starts a run of N generations; the board steps once per
//   clock until N generations are applied or the board stops changing.
//   A saturating generation counter tracks progress since the last load.
//
// Parameters:
//   board_width_p   columns W (>= 3)
//   board_height_p  rows H (>= 3)
//   wrap_p          0: off-board neighbours are dead; 1: toroidal board
//   gen_width_p     width of generation request and counter
//
// Ports:
//   clk_i     clock
//   reset_i   asynchronous active-high reset
//   bus       bsg_cgol_rule_array_if.slave: load/start handshake, rule
//             masks, board readout, generation count and status flags
// ---------------------------------------------------------------------------
module bsg_cgol_rule_array #(
    parameter int board_width_p  = 8,
    parameter int board_height_p = 8,
    parameter int wrap_p         = 0,
    parameter int gen_width_p    = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    bsg_cgol_rule_array_if.slave  bus
);

    localparam int cells_lp = board_width_p * board_height_p;
    localparam int idx_w_lp = $clog2(cells_lp);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                 state_q,     state_n;
    logic [cells_lp-1:0]    board_q,     board_n;
    logic [gen_width_p-1:0] gen_q,       gen_n;
    logic [gen_width_p-1:0] remaining_q, remaining_n;
    logic [8:0]             birth_q,     birth_n;
    logic [8:0]             survive_q,   survive_n;
    logic                   stable_q,    stable_n;

    logic [cells_lp-1:0]    next_board;
    logic                   ready;
    logic                   done;

    // Flat bit position of cell (r,c); row 0 / column 0 sits at the MSB so
    // the image reads left-to-right, top-to-bottom in a hex dump.
    function automatic logic [idx_w_lp-1:0] cell_idx(input int r, input int c);
        return idx_w_lp'(cells_lp - 1 - r * board_width_p - c);
    endfunction

    // Next generation of the whole board from the current board and the
    // rule latched at start. Every cell sums its eight neighbours (0..8)
    // and looks the count up in the survive or birth mask depending on its
    // own state. Without wrap, neighbours off the edge count as dead; with
    // wrap, row/column indices fold modulo H/W, so corners fold both ways.
    always_comb begin : next_board_logic
        logic [3:0] nbr_cnt;
        int         rr;
        int         cc;
        logic       in_board;

        next_board = '0;
        nbr_cnt    = 4'd0;
        rr         = 0;
        cc         = 0;
        in_board   = 1'b0;

        for (int r = 0; r < board_height_p; r++) begin
            for (int c = 0; c < board_width_p; c++) begin
                nbr_cnt = 4'd0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            rr = r + dr;
                            cc = c + dc;
                            if (wrap_p != 0) begin
                                rr       = (rr + board_height_p) % board_height_p;
                                cc       = (cc + board_width_p) % board_width_p;
                                in_board = 1'b1;
                            end else begin
                                in_board = (rr >= 0) && (rr < board_height_p) &&
                                           (cc >= 0) && (cc < board_width_p);
                            end
                            if (in_board) begin
                                nbr_cnt = nbr_cnt + {3'b000, board_q[cell_idx(rr, cc)]};
                            end
                        end
                    end
                end
                next_board[cell_idx(r, c)] = board_q[cell_idx(r, c)] ? survive_q[nbr_cnt]
                                                                      : birth_q[nbr_cnt];
            end
        end
    end

    // State and datapath registers. Reset is immediate so a run in progress
    // is abandoned with the board cleared and no completion pulse.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            board_q     <= '0;
            gen_q       <= '0;
            remaining_q <= '0;
            birth_q     <= '0;
            survive_q   <= '0;
            stable_q    <= 1'b0;
        end else begin
            state_q     <= state_n;
            board_q     <= board_n;
            gen_q       <= gen_n;
            remaining_q <= remaining_n;
            birth_q     <= birth_n;
            survive_q   <= survive_n;
            stable_q    <= stable_n;
        end
    end

    // Run controller. In IDLE a load and a start may arrive together; the
    // load lands in the board this cycle, so the first RUN cycle already
    // steps the freshly loaded image. In RUN an unchanged next board means
    // the pattern has settled: nothing is written, the counter is left
    // alone and the run ends early with stable set. Requests seen outside
    // IDLE are simply dropped.
    always_comb begin : fsm_logic
        state_n     = state_q;
        board_n     = board_q;
        gen_n       = gen_q;
        remaining_n = remaining_q;
        birth_n     = birth_q;
        survive_n   = survive_q;
        stable_n    = stable_q;
        ready       = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (bus.load_v_i) begin
                    board_n  = bus.data_i;
                    gen_n    = '0;
                    stable_n = 1'b0;
                end
                if (bus.start_v_i) begin
                    birth_n     = bus.birth_mask_i;
                    survive_n   = bus.survive_mask_i;
                    remaining_n = bus.num_gens_i;
                    stable_n    = 1'b0;
                    state_n     = (bus.num_gens_i == '0) ? DONE : RUN;
                end
            end

            RUN: begin
                if (next_board == board_q) begin
                    stable_n = 1'b1;
                    state_n  = DONE;
                end else begin
                    board_n     = next_board;
                    gen_n       = (gen_q == '1) ? gen_q : gen_q + gen_width_p'(1);
                    remaining_n = remaining_q - gen_width_p'(1);
                    if (remaining_q == gen_width_p'(1)) begin
                        state_n = DONE;
                    end
                end
            end

            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Readout and status straight from the registers; extinct is a pure
    // function of the board so it tracks loads and resets immediately.
    assign bus.ready_o   = ready;
    assign bus.done_o    = done;
    assign bus.data_o    = board_q;
    assign bus.gen_cnt_o = gen_q;
    assign bus.stable_o  = stable_q;
    assign bus.extinct_o = ~|board_q;

endmodule

// File: tb/tb_bsg_cgol_rule_array.sv
// ---------------------------------------------------------------------------
// tb_bsg_cgol_rule_array
//
// Purpose:
//   Self-checking bench for bsg_cgol_rule_array. Two 8x8 boards share one
//   clock and reset: one with dead padding at the edges, one toroidal.
//   Each table entry loads/starts a run; the expected final state is pushed
//   to a scoreboard queue when the run is started and popped when done_o
//   appears. Hand-written sequences cover reset during a run.
//
// Board images are 64-bit hex: byte r (from the MSB) is row r, and inside a
// byte column 0 is the MSB.
// ---------------------------------------------------------------------------
module tb_bsg_cgol_rule_array;

    localparam int W   = 8;
    localparam int H   = 8;
    localparam int GW  = 16;

    localparam logic [8:0] CONWAY_B = 9'h008;
    localparam logic [8:0] CONWAY_S = 9'h00C;

    logic clk;
    logic rst;

    bsg_cgol_rule_array_if #(.board_width_p(W), .board_height_p(H), .gen_width_p(GW)) bus0 ();
    bsg_cgol_rule_array_if #(.board_width_p(W), .board_height_p(H), .gen_width_p(GW)) bus1 ();

    bsg_cgol_rule_array #(
        .board_width_p (W),
        .board_height_p(H),
        .wrap_p        (0),
        .gen_width_p   (GW)
    ) u_dut_flat (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (bus0)
    );

    bsg_cgol_rule_array #(
        .board_width_p (W),
        .board_height_p(H),
        .wrap_p        (1),
        .gen_width_p   (GW)
    ) u_dut_torus (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          sel;         // 0: flat board, 1: toroidal board
        bit          do_load;
        logic [63:0] board_in;
        logic [15:0] num_gens;
        logic [8:0]  birth;
        logic [8:0]  survive;
        logic [63:0] exp_board;
        logic [15:0] exp_gen;
        bit          exp_stable;
        int          exp_done;    // cycle of done_o, accept cycle = 0
        int          inject_cyc;  // cycle in which ignored load/start are driven (0: none)
    } vec_t;

    typedef struct {
        string       name;
        logic [63:0] exp_board;
        logic [15:0] exp_gen;
        bit          exp_stable;
        int          exp_done;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_inputs(input bit sel, input bit load, input logic [63:0] data,
                              input bit start, input logic [15:0] gens,
                              input logic [8:0] birth, input logic [8:0] survive);
        if (sel) begin
            bus1.load_v_i = load;  bus1.data_i = data;  bus1.start_v_i = start;
            bus1.num_gens_i = gens; bus1.birth_mask_i = birth; bus1.survive_mask_i = survive;
        end else begin
            bus0.load_v_i = load;  bus0.data_i = data;  bus0.start_v_i = start;
            bus0.num_gens_i = gens; bus0.birth_mask_i = birth; bus0.survive_mask_i = survive;
        end
    endtask

    function automatic logic [63:0] rd_data(input bit sel);
        return sel ? bus1.data_o : bus0.data_o;
    endfunction
    function automatic logic [15:0] rd_gen(input bit sel);
        return sel ? bus1.gen_cnt_o : bus0.gen_cnt_o;
    endfunction
    function automatic logic rd_ready(input bit sel);
        return sel ? bus1.ready_o : bus0.ready_o;
    endfunction
    function automatic logic rd_done(input bit sel);
        return sel ? bus1.done_o : bus0.done_o;
    endfunction
    function automatic logic rd_stable(input bit sel);
        return sel ? bus1.stable_o : bus0.stable_o;
    endfunction
    function automatic logic rd_extinct(input bit sel);
        return sel ? bus1.extinct_o : bus0.extinct_o;
    endfunction

    // Drive load/start for one cycle starting at a negedge and record what
    // the run must end with.
    task automatic apply_stimulus(input vec_t v);
        exp_t e;
        set_inputs(v.sel, v.do_load, v.board_in, 1'b1, v.num_gens, v.birth, v.survive);
        e.name       = v.name;
        e.exp_board  = v.exp_board;
        e.exp_gen    = v.exp_gen;
        e.exp_stable = v.exp_stable;
        e.exp_done   = v.exp_done;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        set_inputs(v.sel, 1'b0, '0, 1'b0, '0, '0, '0);
    endtask

    // Follow one run to its done_o pulse (bounded), then compare against
    // the scoreboard entry and check the cycle after the pulse.
    task automatic run_vector(input vec_t v);
        exp_t e;
        int   cyc;
        bit   got;
        bit   ready_bad;
        apply_stimulus(v);
        cyc = 0;
        got = 1'b0;
        ready_bad = 1'b0;
        while (!got && cyc < v.exp_done + 10) begin
            @(negedge clk);
            cyc++;
            if (v.inject_cyc != 0 && cyc == v.inject_cyc) begin
                set_inputs(v.sel, 1'b1, '1, 1'b1, 16'd1, CONWAY_B, CONWAY_S);
            end else begin
                set_inputs(v.sel, 1'b0, '0, 1'b0, '0, '0, '0);
            end
            if (rd_done(v.sel)) got = 1'b1;
            else if (rd_ready(v.sel)) ready_bad = 1'b1;
        end
        e = sb_q.pop_front();
        check_output({e.name, ".done_cycle"}, 64'(cyc), 64'(e.exp_done));
        check_output({e.name, ".ready_low"}, 64'(ready_bad), 64'd0);
        check_output({e.name, ".board"}, rd_data(v.sel), e.exp_board);
        check_output({e.name, ".gen_cnt"}, 64'(rd_gen(v.sel)), 64'(e.exp_gen));
        check_output({e.name, ".stable"}, 64'(rd_stable(v.sel)), 64'(e.exp_stable));
        check_output({e.name, ".extinct"}, 64'(rd_extinct(v.sel)), 64'(e.exp_board == 64'd0));
        @(negedge clk);
        set_inputs(v.sel, 1'b0, '0, 1'b0, '0, '0, '0);
        check_output({e.name, ".done_pulse_end"}, 64'(rd_done(v.sel)), 64'd0);
        check_output({e.name, ".ready_again"}, 64'(rd_ready(v.sel)), 64'd1);
        check_output({e.name, ".board_after"}, rd_data(v.sel), e.exp_board);
    endtask

    vec_t vecs[10];

    initial begin
        vec_t v;
        int   done_seen;

        vecs[0] = '{"blinker", 1'b0, 1'b1, 64'h0000_0038_0000_0000, 16'd1, CONWAY_B, CONWAY_S,
                    64'h0000_1010_1000_0000, 16'd1, 1'b0, 2, 0};
        vecs[1] = '{"single_cell", 1'b0, 1'b1, 64'h0000_0000_0800_0000, 16'd5, CONWAY_B, CONWAY_S,
                    64'h0, 16'd1, 1'b1, 3, 0};
        vecs[2] = '{"block", 1'b0, 1'b1, 64'h0000_0018_1800_0000, 16'd10, CONWAY_B, CONWAY_S,
                    64'h0000_0018_1800_0000, 16'd0, 1'b1, 2, 0};
        vecs[3] = '{"zero_gens", 1'b0, 1'b0, 64'h0, 16'd0, CONWAY_B, CONWAY_S,
                    64'h0000_0018_1800_0000, 16'd0, 1'b0, 1, 1};
        vecs[4] = '{"edge_flat", 1'b0, 1'b1, 64'hE000_0000_0000_0000, 16'd1, CONWAY_B, CONWAY_S,
                    64'h4040_0000_0000_0000, 16'd1, 1'b0, 2, 0};
        vecs[5] = '{"seeds_rule", 1'b0, 1'b1, 64'h0000_0018_0000_0000, 16'd1, 9'h004, 9'h000,
                    64'h0000_1800_1800_0000, 16'd1, 1'b0, 2, 0};
        vecs[6] = '{"edge_torus", 1'b1, 1'b1, 64'hE000_0000_0000_0000, 16'd1, CONWAY_B, CONWAY_S,
                    64'h4040_0000_0000_0040, 16'd1, 1'b0, 2, 0};
        vecs[7] = '{"glider32", 1'b1, 1'b1, 64'h4020_E000_0000_0000, 16'd32, CONWAY_B, CONWAY_S,
                    64'h4020_E000_0000_0000, 16'd32, 1'b0, 33, 3};
        vecs[8] = '{"glider_more", 1'b1, 1'b0, 64'h0, 16'd4, CONWAY_B, CONWAY_S,
                    64'h0020_1070_0000_0000, 16'd36, 1'b0, 5, 0};
        vecs[9] = '{"post_reset", 1'b1, 1'b1, 64'h0000_0038_0000_0000, 16'd1, CONWAY_B, CONWAY_S,
                    64'h0000_1010_1000_0000, 16'd1, 1'b0, 2, 0};

        rst = 1'b1;
        set_inputs(1'b0, 1'b0, '0, 1'b0, '0, '0, '0);
        set_inputs(1'b1, 1'b0, '0, 1'b0, '0, '0, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int s = 0; s < 2; s++) begin
            check_output($sformatf("reset%0d.board", s), rd_data(s[0]), 64'd0);
            check_output($sformatf("reset%0d.ready", s), 64'(rd_ready(s[0])), 64'd1);
            check_output($sformatf("reset%0d.done", s), 64'(rd_done(s[0])), 64'd0);
            check_output($sformatf("reset%0d.gen_cnt", s), 64'(rd_gen(s[0])), 64'd0);
            check_output($sformatf("reset%0d.stable", s), 64'(rd_stable(s[0])), 64'd0);
            check_output($sformatf("reset%0d.extinct", s), 64'(rd_extinct(s[0])), 64'd1);
        end

        for (int i = 0; i < 9; i++) begin
            run_vector(vecs[i]);
        end

        // Reset in the middle of a long run on the toroidal board.
        set_inputs(1'b1, 1'b1, 64'h4020_E000_0000_0000, 1'b1, 16'd100, CONWAY_B, CONWAY_S);
        @(posedge clk);
        #1;
        set_inputs(1'b1, 1'b0, '0, 1'b0, '0, '0, '0);
        repeat (5) @(negedge clk);
        check_output("midrun.busy_before_reset", 64'(rd_ready(1'b1)), 64'd0);
        rst = 1'b1;
        #1;
        check_output("midrun.board", rd_data(1'b1), 64'd0);
        check_output("midrun.ready", 64'(rd_ready(1'b1)), 64'd1);
        check_output("midrun.gen_cnt", 64'(rd_gen(1'b1)), 64'd0);
        check_output("midrun.done", 64'(rd_done(1'b1)), 64'd0);
        check_output("midrun.extinct", 64'(rd_extinct(1'b1)), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 110; c++) begin
            @(negedge clk);
            if (rd_done(1'b1)) done_seen++;
        end
        check_output("midrun.no_done_pulse", 64'(done_seen), 64'd0);

        v = vecs[9];
        run_vector(v);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
